// File: rtl/des_key_schedule.sv
// DES subkey responder: holds PC-1 key as C/D halves, walks rotations to the requested round, emits PC-2.
// Latency: 1 + |target - pos| cycles from accepted request to subkey_valid.
// No backpressure: requests during seek/response are dropped; optional KEY_PARITY_CHECK_EN flags even-parity key bytes.
module des_key_schedule #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [63:0] key,
  input  logic        mode,
  input  logic        subkey_req,
  input  logic [15:0] round_counter,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic        key_ready,
  output logic        busy,
  output logic        index_err,
  output logic        key_parity_err
);

  localparam int POS_W   = IDX_W + 1;
  localparam int MAX_IDX = (1 << IDX_W) - 1;

  typedef enum logic [1:0] {NOKEY, READY, SEEK, RESP} state_t;

  // Tables use DES numbering: bit 1 is the MSB.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic single_shift(input logic [POS_W-1:0] n);
    return (n == POS_W'(1)) || (n == POS_W'(2)) || (n == POS_W'(9)) || (n == POS_W'(16));
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  state_t             state;
  logic [27:0]        c_q;
  logic [27:0]        d_q;
  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   target;

  logic [IDX_W-1:0]   req_idx;
  logic [POS_W-1:0]   req_target;
  logic               req_range_err;
  logic [POS_W-1:0]   pos_inc;
  logic [POS_W-1:0]   pos_dec;

  // In decrypt mode 15 - idx equals the bitwise complement of idx.
  assign req_idx       = mode ? ~round_counter[IDX_W-1:0] : round_counter[IDX_W-1:0];
  assign req_target    = {1'b0, req_idx} + POS_W'(1);
  assign req_range_err = round_counter > 16'(MAX_IDX);
  assign pos_inc       = pos + POS_W'(1);
  assign pos_dec       = pos - POS_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= NOKEY;
      c_q          <= '0;
      d_q          <= '0;
      pos          <= '0;
      target       <= '0;
      subkey       <= '0;
      subkey_valid <= 1'b0;
      key_ready    <= 1'b0;
      busy         <= 1'b0;
      index_err    <= 1'b0;
    end else begin
      subkey_valid <= 1'b0;
      index_err    <= 1'b0;
      if (key_load) begin
        // Load has priority: any in-flight seek or response is abandoned silently.
        {c_q, d_q} <= pc1(key);
        pos        <= '0;
        state      <= READY;
        key_ready  <= 1'b1;
        busy       <= 1'b0;
      end else begin
        case (state)
          READY: begin
            if (subkey_req) begin
              if (req_range_err) begin
                index_err <= 1'b1;
              end else begin
                target <= req_target;
                if (req_target == pos) begin
                  state <= RESP;
                end else begin
                  state <= SEEK;
                  busy  <= 1'b1;
                end
              end
            end
          end
          SEEK: begin
            if (pos < target) begin
              c_q <= rotl(c_q, single_shift(pos_inc));
              d_q <= rotl(d_q, single_shift(pos_inc));
              pos <= pos_inc;
              if (pos_inc == target) begin
                state <= RESP;
                busy  <= 1'b0;
              end
            end else if (pos > target) begin
              c_q <= rotr(c_q, single_shift(pos));
              d_q <= rotr(d_q, single_shift(pos));
              pos <= pos_dec;
              if (pos_dec == target) begin
                state <= RESP;
                busy  <= 1'b0;
              end
            end else begin
              state <= RESP;
              busy  <= 1'b0;
            end
          end
          RESP: begin
            subkey       <= pc2({c_q, d_q});
            subkey_valid <= 1'b1;
            state        <= READY;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef KEY_PARITY_CHECK_EN
  logic parity_bad;

  always_comb begin
    parity_bad = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (!(^key[8*b +: 8])) parity_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_parity_err <= 1'b0;
    end else if (key_load) begin
      key_parity_err <= parity_bad;
    end
  end
`else
  logic parity_bits_unused;

  assign key_parity_err     = 1'b0;
  assign parity_bits_unused = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized bench for des_key_schedule against a direct cumulative-shift DES key schedule model.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_load;
  logic [63:0] key;
  logic        mode;
  logic        subkey_req;
  logic [15:0] round_counter;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        key_ready;
  logic        busy;
  logic        index_err;
  logic        key_parity_err;

  always #5 clk = ~clk;

  des_key_schedule #(.IDX_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .key_load       (key_load),
    .key            (key),
    .mode           (mode),
    .subkey_req     (subkey_req),
    .round_counter  (round_counter),
    .subkey         (subkey),
    .subkey_valid   (subkey_valid),
    .key_ready      (key_ready),
    .busy           (busy),
    .index_err      (index_err),
    .key_parity_err (key_parity_err)
  );

  int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] BAD_KEY = 64'h123457799BBCDFF1;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_pos;
  logic [63:0] m_key;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Subkey for index idx: PC-1, rotate each half by the summed shift schedule, PC-2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int idx);
    logic [55:0] cd;
    logic [55:0] cc;
    logic [55:0] dd;
    logic [47:0] r;
    int          s;
    for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - PC1[i]];
    s = 0;
    for (int n = 1; n <= idx + 1; n++) s += (n == 1 || n == 2 || n == 9 || n == 16) ? 1 : 2;
    s = s % 28;
    cc = {cd[55:28], cd[55:28]};
    dd = {cd[27:0], cd[27:0]};
    cd = {cc[55 - s -: 28], dd[55 - s -: 28]};
    for (int i = 0; i < 48; i++) r[47 - i] = cd[56 - PC2[i]];
    return r;
  endfunction

  function automatic logic exp_parity_err(input logic [63:0] k);
`ifdef KEY_PARITY_CHECK_EN
    for (int b = 0; b < 8; b++) begin
      if ($countones(k[8*b +: 8]) % 2 == 0) return 1'b1;
    end
    return 1'b0;
`else
    return (k === 64'hx);
`endif
  endfunction

  task automatic load(input logic [63:0] k);
    key      = k;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    m_key    = k;
    m_pos    = 0;
    check("key_ready", 64'(key_ready), 64'd1);
    check("key_parity_err", 64'(key_parity_err), 64'(exp_parity_err(k)));
  endtask

  task automatic request(input logic [15:0] rc, input logic md, input bit poke);
    int          idx;
    int          tgt;
    int          lat;
    int          cyc;
    int          busy_cnt;
    bit          seen;
    logic [47:0] exp_sk;
    subkey_req    = 1'b1;
    round_counter = rc;
    mode          = md;
    @(posedge clk); #1;
    subkey_req = 1'b0;
    if (rc > 16'd15) begin
      check("index_err", 64'(index_err), 64'd1);
      seen = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        if (subkey_valid || busy || index_err) seen = 1'b1;
      end
      check("index_err_quiet", 64'(seen), 64'd0);
      return;
    end
    idx    = md ? 15 - int'(rc) : int'(rc);
    tgt    = idx + 1;
    lat    = 1 + ((tgt > m_pos) ? tgt - m_pos : m_pos - tgt);
    exp_sk = ref_subkey(m_key, idx);
    cyc      = 0;
    busy_cnt = 0;
    while (!subkey_valid && cyc < 40) begin
      if (busy) busy_cnt++;
      if (poke && cyc == 1) begin
        subkey_req    = 1'b1;
        round_counter = 16'($urandom_range(0, 15));
        mode          = ~md;
      end else begin
        subkey_req = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    subkey_req = 1'b0;
    check("latency", 64'(cyc), 64'(lat));
    check("subkey", 64'(subkey), 64'(exp_sk));
    check("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
    m_pos = tgt;
    if (poke) begin
      @(posedge clk); #1;
      check("busy_req_ignored", 64'({subkey_valid, busy}), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] k;
    logic [15:0] rc;
    bit          seen;

    rst           = 1'b1;
    key_load      = 1'b0;
    key           = '0;
    mode          = 1'b0;
    subkey_req    = 1'b0;
    round_counter = '0;
    m_key         = '0;
    m_pos         = 0;
    repeat (2) @(posedge clk); #1;
    check("rst_outputs", 64'({subkey, subkey_valid, key_ready, busy, index_err, key_parity_err}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a long seek.
    load(KAT_KEY);
    subkey_req    = 1'b1;
    mode          = 1'b1;
    round_counter = 16'd0;
    @(posedge clk); #1;
    subkey_req = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("busy_mid_seek", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_seek", 64'({subkey, subkey_valid, key_ready, busy, index_err, key_parity_err}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    subkey_req    = 1'b1;
    round_counter = 16'd0;
    mode          = 1'b0;
    @(posedge clk); #1;
    subkey_req = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      if (subkey_valid || busy || key_ready) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("nokey_ignores_req", 64'(seen), 64'd0);

    // Known-answer vectors.
    load(KAT_KEY);
    request(16'd0, 1'b0, 1'b0);
    check("kat_enc_k1", 64'(subkey), 64'h1B02EFFC7072);
    request(16'd1, 1'b0, 1'b0);
    check("kat_enc_k2", 64'(subkey), 64'h79AED9DBC9E5);
    load(KAT_KEY);
    request(16'd0, 1'b1, 1'b0);
    check("kat_dec_k16", 64'(subkey), 64'hCB3D8B0E17F5);
    request(16'd15, 1'b1, 1'b0);
    check("kat_dec_k1", 64'(subkey), 64'h1B02EFFC7072);
    request(16'd16, 1'b0, 1'b0);

    // Load and request together: request dropped, position back to 0.
    key           = KAT_KEY;
    key_load      = 1'b1;
    subkey_req    = 1'b1;
    round_counter = 16'd7;
    mode          = 1'b0;
    @(posedge clk); #1;
    key_load   = 1'b0;
    subkey_req = 1'b0;
    m_key      = KAT_KEY;
    m_pos      = 0;
    seen = 1'b0;
    repeat (12) begin
      if (subkey_valid || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("load_wins_drop", 64'(seen), 64'd0);
    request(16'd0, 1'b0, 1'b0);

    load(BAD_KEY);
    load(KAT_KEY);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        k = {$urandom, $urandom};
        load(k);
      end
      if ($urandom_range(0, 9) == 0) rc = 16'($urandom_range(16, 65535));
      else rc = 16'($urandom_range(0, 15));
      request(rc, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
